tw_horizontal_loader: RTL and testbench



---
 rtl/tw_horizontal_loader_pkg.sv | 27 ++
 rtl/tw_horizontal_loader_if.sv | 30 +++
 rtl/tw_horizontal_loader_word_buf.sv | 38 +++
 rtl/tw_horizontal_loader.sv | 150 +++++++++++++++
 tb/tb_tw_horizontal_loader.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tw_horizontal_loader_pkg.sv
// Shared types and constants for the stage-0 twiddle horizontal loader.
// Also imported by the TW_ROM4 benches.
package tw_load_pkg;

  localparam int P_WIDTH_DEFAULT    = 128;
  localparam int HDW_DEFAULT        = 64;
  localparam int DEPTH_DEFAULT      = 4;
  localparam int GAP_CYCLES_DEFAULT = 1;

  typedef enum logic [2:0] {
    FILL    = 3'd0,
    READY   = 3'd1,
    SEND_HI = 3'd2,
    SEND_LO = 3'd3,
    GAP     = 3'd4
  } state_t;

  localparam logic [1:0] ROM4_W_IDLE = 2'd0;
  localparam logic [1:0] ROM4_W_HI   = 2'd1;
  localparam logic [1:0] ROM4_W_LO   = 2'd2;

  // Counter width that stays at least one bit for a modulus of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tw_horizontal_loader_if.sv
// Upstream twiddle-word handshake plus the TW_ROM4 write bus.
// slave = loader side, master = source/receiver side.
interface tw_horizontal_loader_if #(
  parameter int P_WIDTH       = 128,
  parameter int horizontal_DW = 64
) ();

  logic                     tw_valid;
  logic                     tw_ready;
  logic [P_WIDTH-1:0]       tw_data;
  logic [horizontal_DW-1:0] horizontal_data_out;
  logic [1:0]               ROM4_w;

  modport master (
    output tw_valid,
    output tw_data,
    input  tw_ready,
    input  horizontal_data_out,
    input  ROM4_w
  );

  modport slave (
    input  tw_valid,
    input  tw_data,
    output tw_ready,
    output horizontal_data_out,
    output ROM4_w
  );

endinterface

// File: rtl/tw_horizontal_loader_word_buf.sv
// DEPTH x P_WIDTH word store: one write port with synchronous clear,
// combinational read returning either the hi or the lo half of an entry.
module tw_word_buf
  import tw_load_pkg::*;
#(
  parameter int P_WIDTH       = P_WIDTH_DEFAULT,
  parameter int horizontal_DW = HDW_DEFAULT,
  parameter int DEPTH         = DEPTH_DEFAULT,
  parameter int AW            = cnt_width(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [P_WIDTH-1:0]       wr_data,
  input  logic [AW-1:0]            rd_addr,
  input  logic                     rd_hi,
  output logic [horizontal_DW-1:0] rd_data
);

  logic [P_WIDTH-1:0] mem_reg [DEPTH];
  logic [P_WIDTH-1:0] rd_word;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  assign rd_word = mem_reg[rd_addr];
  assign rd_data = rd_hi ? rd_word[P_WIDTH-1:horizontal_DW]
                         : rd_word[horizontal_DW-1:0];

endmodule

// File: rtl/tw_horizontal_loader.sv
// Collects DEPTH twiddle words, then on start streams every hi half followed
// by every lo half to TW_ROM4 as one unbroken burst, then idles GAP_CYCLES.
module tw_horizontal_loader
  import tw_load_pkg::*;
#(
  parameter int P_WIDTH       = P_WIDTH_DEFAULT,
  parameter int horizontal_DW = HDW_DEFAULT,
  parameter int DEPTH         = DEPTH_DEFAULT,
  parameter int GAP_CYCLES    = GAP_CYCLES_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  tw_horizontal_loader_if.slave bus,
  input  logic                  start,
  output logic                  busy,
  output logic                  done
);

  localparam int BW = cnt_width(DEPTH);
  localparam int GW = cnt_width(GAP_CYCLES);
  localparam logic [BW-1:0] LAST_BEAT = BW'(DEPTH - 1);
  localparam logic [GW-1:0] LAST_GAP  = GW'(GAP_CYCLES - 1);

  state_t                   state_reg, state_next;
  logic [BW-1:0]            wr_ptr_reg, wr_ptr_next;
  logic [BW-1:0]            beat_cnt_reg, beat_cnt_next;
  logic [GW-1:0]            gap_cnt_reg, gap_cnt_next;
  logic [horizontal_DW-1:0] data_reg, data_next;
  logic [horizontal_DW-1:0] rd_data;
  logic [1:0]               rom_w_reg, rom_w_next;
  logic                     busy_reg, busy_next;
  logic                     done_reg, done_next;
  logic                     accept;

  assign bus.tw_ready = (state_reg == FILL);
  assign accept       = bus.tw_valid && (state_reg == FILL);

  // Read address follows the next beat so the registered output lines up
  // with the state it belongs to (first beat visible the cycle after start).
  tw_word_buf #(
    .P_WIDTH       (P_WIDTH),
    .horizontal_DW (horizontal_DW),
    .DEPTH         (DEPTH),
    .AW            (BW)
  ) u_word_buf (
    .clk     (CLK),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_addr (wr_ptr_reg),
    .wr_data (bus.tw_data),
    .rd_addr (beat_cnt_next),
    .rd_hi   (state_next == SEND_HI),
    .rd_data (rd_data)
  );

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_reg    <= FILL;
      wr_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
      data_reg     <= '0;
      rom_w_reg    <= ROM4_W_IDLE;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wr_ptr_reg   <= wr_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      data_reg     <= data_next;
      rom_w_reg    <= rom_w_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wr_ptr_next   = wr_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    case (state_reg)
      FILL: begin
        if (accept) begin
          if (wr_ptr_reg == LAST_BEAT) begin
            wr_ptr_next = '0;
            state_next  = READY;
          end else begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
          end
        end
      end
      READY: begin
        if (start) begin
          state_next    = SEND_HI;
          beat_cnt_next = '0;
        end
      end
      SEND_HI: begin
        if (beat_cnt_reg == LAST_BEAT) begin
          beat_cnt_next = '0;
          state_next    = SEND_LO;
        end else begin
          beat_cnt_next = beat_cnt_reg + 1'b1;
        end
      end
      SEND_LO: begin
        if (beat_cnt_reg == LAST_BEAT) begin
          beat_cnt_next = '0;
          gap_cnt_next  = '0;
          state_next    = GAP;
        end else begin
          beat_cnt_next = beat_cnt_reg + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_reg == LAST_GAP) begin
          gap_cnt_next = '0;
          state_next   = FILL;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // Output values are decoded from the upcoming state and registered.
  always_comb begin
    rom_w_next = ROM4_W_IDLE;
    data_next  = '0;
    if (state_next == SEND_HI) begin
      rom_w_next = ROM4_W_HI;
      data_next  = rd_data;
    end else if (state_next == SEND_LO) begin
      rom_w_next = ROM4_W_LO;
      data_next  = rd_data;
    end
    busy_next = (state_next == SEND_HI) || (state_next == SEND_LO) ||
                (state_next == GAP);
    done_next = (state_next == GAP) && (state_reg != GAP);
  end

  assign bus.horizontal_data_out = data_reg;
  assign bus.ROM4_w              = rom_w_reg;
  assign busy                    = busy_reg;
  assign done                    = done_reg;

endmodule

// File: tb/tb_tw_horizontal_loader.sv
// Bench for tw_horizontal_loader: a DEPTH=4/GAP=1 and a DEPTH=8/GAP=3 instance,
// a directed cycle table, and a timeline reference model with a receiver model.
module tb_tw_horizontal_loader;
  import tw_load_pkg::*;

  localparam int PW = 128;
  localparam int HW = 64;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          rst_n = 1'b0;
  logic          sel = 1'b0;
  logic          drv_valid = 1'b0;
  logic [PW-1:0] drv_data = '0;
  logic          drv_start = 1'b0;
  logic          busy4, busy8, done4, done8;

  tw_horizontal_loader_if #(.P_WIDTH(PW), .horizontal_DW(HW)) bus4 ();
  tw_horizontal_loader_if #(.P_WIDTH(PW), .horizontal_DW(HW)) bus8 ();

  assign bus4.tw_valid = drv_valid & ~sel;
  assign bus8.tw_valid = drv_valid & sel;
  assign bus4.tw_data  = drv_data;
  assign bus8.tw_data  = drv_data;

  tw_horizontal_loader #(.P_WIDTH(PW), .horizontal_DW(HW), .DEPTH(4), .GAP_CYCLES(1)) dut4 (
    .CLK(CLK), .rst_n(rst_n), .bus(bus4), .start(drv_start & ~sel), .busy(busy4), .done(done4));
  tw_horizontal_loader #(.P_WIDTH(PW), .horizontal_DW(HW), .DEPTH(8), .GAP_CYCLES(3)) dut8 (
    .CLK(CLK), .rst_n(rst_n), .bus(bus8), .start(drv_start & sel), .busy(busy8), .done(done8));

  logic          mon_ready, mon_busy, mon_done;
  logic [1:0]    mon_rom;
  logic [HW-1:0] mon_data;
  assign mon_ready = sel ? bus8.tw_ready : bus4.tw_ready;
  assign mon_busy  = sel ? busy8 : busy4;
  assign mon_done  = sel ? done8 : done4;
  assign mon_rom   = sel ? bus8.ROM4_w : bus4.ROM4_w;
  assign mon_data  = sel ? bus8.horizontal_data_out : bus4.horizontal_data_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  string tag  = "init";

  // Reference model: m_t counts cycles since the start edge (-1 = not bursting).
  int            m_d = 4, m_g = 1, m_t = -1, m_cnt = 0;
  bit            m_full = 1'b0;
  logic [PW-1:0] m_buf [8];
  // Receiver model: row counter cleared whenever ROM4_w is idle.
  logic [HW-1:0] rx_hi [8];
  logic [HW-1:0] rx_lo [8];
  int            rx_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s cyc %0d: got %h, expected %h", tag, name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input logic v, input logic [PW-1:0] d, input logic s, input logic r);
    if (!r) begin
      m_t = -1; m_full = 1'b0; m_cnt = 0;
    end else if (m_t >= 0) begin
      m_t++;
      if (m_t == 2*m_d + m_g + 1) m_t = -1;
    end else if (!m_full) begin
      if (v) begin
        m_buf[m_cnt] = d;
        m_cnt++;
        if (m_cnt == m_d) begin m_full = 1'b1; m_cnt = 0; end
      end
    end else if (s) begin
      m_t = 1; m_full = 1'b0;
    end
  endtask

  task automatic check_model();
    logic          e_rdy, e_busy, e_done;
    logic [1:0]    e_rom;
    logic [HW-1:0] e_data;
    e_rdy = (m_t < 0) && !m_full;
    e_rom = ROM4_W_IDLE; e_data = '0;
    if (m_t >= 1 && m_t <= m_d) begin
      e_rom = ROM4_W_HI; e_data = m_buf[m_t-1][PW-1:HW];
    end else if (m_t > m_d && m_t <= 2*m_d) begin
      e_rom = ROM4_W_LO; e_data = m_buf[m_t-1-m_d][HW-1:0];
    end
    e_busy = (m_t >= 1);
    e_done = (m_t == 2*m_d + 1);
    chk("ready", mon_ready, e_rdy);
    chk("rom4_w", mon_rom, e_rom);
    chk("data", mon_data, e_data);
    chk("busy", mon_busy, e_busy);
    chk("done", mon_done, e_done);
    if (m_t == 2*m_d + 1) begin
      for (int i = 0; i < m_d; i++) begin
        chk("rx_hi", rx_hi[i], m_buf[i][PW-1:HW]);
        chk("rx_lo", rx_lo[i], m_buf[i][HW-1:0]);
      end
    end
  endtask

  task automatic rx_update();
    if (mon_rom == ROM4_W_IDLE) begin
      rx_cnt = 0;
    end else if (mon_rom == ROM4_W_HI) begin
      rx_hi[rx_cnt] = mon_data; rx_cnt = (rx_cnt + 1) % m_d;
    end else if (mon_rom == ROM4_W_LO) begin
      rx_lo[rx_cnt] = mon_data; rx_cnt = (rx_cnt + 1) % m_d;
    end
  endtask

  task automatic cycle(input logic v, input logic [PW-1:0] d, input logic s, input logic r);
    drv_valid = v; drv_data = d; drv_start = s; rst_n = r;
    @(posedge CLK); #1;
    cyc++;
    model_step(v, d, s, r);
    check_model();
    rx_update();
  endtask

  function automatic logic [PW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drain();
    for (int k = 0; k < 64 && m_t >= 0; k++) cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic random_burst(input int id, input bit eager);
    for (int k = 0; k < 200 && !m_full; k++)
      cycle(eager ? 1'b1 : ($urandom_range(3) != 0), rnd_word(), 1'($urandom_range(1)), 1'b1);
    for (int k = 0; k < 40 && m_t < 0; k++)
      cycle(1'($urandom_range(1)), rnd_word(), eager ? 1'b1 : ($urandom_range(2) == 0), 1'b1);
    for (int k = 0; k < 64 && m_t >= 0; k++)
      cycle(1'($urandom_range(1)), rnd_word(), 1'($urandom_range(1)), 1'b1);
    $display("[TB] %s burst %0d (depth %0d) complete at cyc %0d", tag, id, m_d, cyc);
  endtask

  typedef struct {
    logic          v;
    logic [PW-1:0] d;
    logic          s;
    logic          e_ready;
    logic [1:0]    e_rom;
    logic [HW-1:0] e_data;
    logic          e_busy;
    logic          e_done;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] w0, w1, w2, w3;
    logic [PW-1:0] bp_words [5];
    logic          bp_pat [6];
    int            widx, fall_c, beat_c, n_hi, n_lo, n_idle, done_k;
    bit            acc;

    w0 = 128'h0000000000000001_0000000000000001;
    w1 = 128'hfffffffeffffffc1_52ca810d84ba33e7;
    w2 = 128'h0000000000001000_dfffffff00002001;
    w3 = 128'hfffffffefffc0001_bf8a7473016d6c46;
    tbl[0]  = '{1'b1, w0,  1'b0, 1'b1, 2'd0, 64'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, w1,  1'b0, 1'b1, 2'd0, 64'h0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, w2,  1'b0, 1'b1, 2'd0, 64'h0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, w3,  1'b0, 1'b0, 2'd0, 64'h0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, '0,  1'b1, 1'b0, 2'd1, 64'h0000000000000001, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, '0,  1'b0, 1'b0, 2'd1, 64'hfffffffeffffffc1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, '0,  1'b0, 1'b0, 2'd1, 64'h0000000000001000, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, '0,  1'b0, 1'b0, 2'd1, 64'hfffffffefffc0001, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, '0,  1'b0, 1'b0, 2'd2, 64'h0000000000000001, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, '0,  1'b0, 1'b0, 2'd2, 64'h52ca810d84ba33e7, 1'b1, 1'b0};
    tbl[10] = '{1'b0, '0,  1'b0, 1'b0, 2'd2, 64'hdfffffff00002001, 1'b1, 1'b0};
    tbl[11] = '{1'b0, '0,  1'b0, 1'b0, 2'd2, 64'hbf8a7473016d6c46, 1'b1, 1'b0};
    tbl[12] = '{1'b0, '0,  1'b0, 1'b0, 2'd0, 64'h0, 1'b1, 1'b1};
    tbl[13] = '{1'b0, '0,  1'b0, 1'b1, 2'd0, 64'h0, 1'b0, 1'b0};

    // Reset values.
    tag = "reset";
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Directed basic burst, cycle by cycle.
    tag = "table";
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].s, 1'b1);
      chk("t_ready", mon_ready, tbl[i].e_ready);
      chk("t_rom4_w", mon_rom, tbl[i].e_rom);
      chk("t_data", mon_data, tbl[i].e_data);
      chk("t_busy", mon_busy, tbl[i].e_busy);
      chk("t_done", mon_done, tbl[i].e_done);
      $display("[TB] table row %0d rom4_w=%0d data=%h", i, mon_rom, mon_data);
    end

    // Backpressure: gapped valid, then a fifth word offered while READY.
    tag = "backpressure";
    bp_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) bp_words[i] = rnd_word();
    widx = 0;
    for (int k = 0; k < 6; k++) begin
      acc = bp_pat[k] && (m_t < 0) && !m_full;
      cycle(bp_pat[k], bp_words[widx], 1'b0, 1'b1);
      if (acc) widx++;
    end
    chk("bp_ready_after_4", mon_ready, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b1, bp_words[4], 1'b0, 1'b1);
    cycle(1'b1, bp_words[4], 1'b1, 1'b1);
    drain();
    $display("[TB] backpressure burst complete at cyc %0d", cyc);

    // Early start: start held high through the whole fill and beyond.
    tag = "early_start";
    fall_c = -1; beat_c = -1;
    for (int k = 0; k < 12; k++) begin
      cycle(k < 4, rnd_word(), 1'b1, 1'b1);
      if (fall_c < 0 && !mon_ready) fall_c = cyc;
      if (beat_c < 0 && mon_rom != ROM4_W_IDLE) beat_c = cyc;
    end
    // READY is seen one sample after the 4th accept; the first beat one later.
    chk("early_latency", 64'(beat_c - fall_c), 64'd1);
    drain();

    // Reset on the 3rd SEND_LO beat, then a fresh load.
    tag = "reset_mid";
    for (int k = 0; k < 4; k++) cycle(1'b1, rnd_word(), 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    for (int k = 0; k < 20 && m_t != m_d + 3; k++) cycle(1'b0, '0, 1'b0, 1'b1);
    chk("pre_rst_rom4_w", mon_rom, ROM4_W_LO);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("rst_rom4_w", mon_rom, ROM4_W_IDLE);
    chk("rst_data", mon_data, 64'h0);
    chk("rst_busy", mon_busy, 1'b0);
    chk("rst_ready", mon_ready, 1'b1);
    random_burst(0, 1'b1);

    // Back-to-back randomized bursts.
    tag = "b2b";
    for (int b = 0; b < 8; b++) random_burst(b, (b % 2) == 0);

    // DEPTH = 8, GAP_CYCLES = 3 instance.
    tag = "depth8";
    sel = 1'b1; m_d = 8; m_g = 3;
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) cycle(1'b1, rnd_word(), 1'b0, 1'b1);
    n_hi = 0; n_lo = 0; n_idle = 0; done_k = -1;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, '0, k == 0, 1'b1);
      if (mon_rom == ROM4_W_HI && n_lo == 0) n_hi++;
      if (mon_rom == ROM4_W_LO && n_hi == 8) n_lo++;
      if (mon_rom == ROM4_W_IDLE && mon_busy) n_idle++;
      if (mon_done) done_k = k;
    end
    chk("d8_hi_beats", 64'(n_hi), 64'd8);
    chk("d8_lo_beats", 64'(n_lo), 64'd8);
    chk("d8_idle", 64'(n_idle), 64'd3);
    chk("d8_done_pos", 64'(done_k), 64'd16);
    chk("d8_ready_back", mon_ready, 1'b1);
    for (int b = 0; b < 3; b++) random_burst(b, b == 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
